// File: rtl/control_unit_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface control_unit_if #(
  parameter int unsigned STATE_W = 5
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               overflow;
  logic               eq;
  logic               pc_write;
  logic [1:0]         iord;
  logic               mem_wr;
  logic               ir_write;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               load_a;
  logic               load_b;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_ctrl;
  logic               alu_out_write;
  logic [1:0]         pc_source;
  logic               epc_write;
  logic [1:0]         excp_code;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, funct, overflow, eq,
    output pc_write, iord, mem_wr, ir_write, reg_write, reg_dst, mem_to_reg,
           load_a, load_b, alu_src_a, alu_src_b, alu_ctrl, alu_out_write,
           pc_source, epc_write, excp_code, state_dbg
  );

  modport slave (
    output opcode, funct, overflow, eq,
    input  pc_write, iord, mem_wr, ir_write, reg_write, reg_dst, mem_to_reg,
           load_a, load_b, alu_src_a, alu_src_b, alu_ctrl, alu_out_write,
           pc_source, epc_write, excp_code, state_dbg
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle main control FSM for the MIPS-subset CPU.
// Optional: define OVERFLOW_EXCP_EN to trap add/sub/addi overflow into the exception path.
module control_unit #(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned STATE_W  = 5
) (
  input  logic           clock,
  input  logic           reset,
  control_unit_if.master ctrl
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT + 1);

`ifdef OVERFLOW_EXCP_EN
  localparam bit OVF_EXCP = 1'b1;
`else
  localparam bit OVF_EXCP = 1'b0;
`endif

  // WB is split by origin so reg_dst stays a pure function of state
  typedef enum logic [STATE_W-1:0] {
    RST, FETCH, DECODE, EXEC_R, EXEC_I, WB_R, WB_I, ADDR,
    MEM_RD, WB_LW, MEM_WR, BR, JMP, EXCP, EXCP_LD
  } state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             waitDone;
  logic [1:0]       excpCode, nextExcpCode;
  logic             rFunctOk;

  assign waitDone       = (waitCnt == CNT_W'(MEM_WAIT - 1));
  assign rFunctOk       = (ctrl.funct == 6'h20) || (ctrl.funct == 6'h22) || (ctrl.funct == 6'h24);
  assign ctrl.state_dbg = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= RST;
      waitCnt  <= '0;
      excpCode <= '0;
    end else begin
      state    <= nextState;
      excpCode <= nextExcpCode;
      if (nextState != state)
        waitCnt <= '0;
      else if (waitCnt != CNT_W'(MEM_WAIT))
        waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  always_comb begin
    nextState          = state;
    nextExcpCode       = excpCode;
    ctrl.pc_write      = 1'b0;
    ctrl.iord          = 2'b00;
    ctrl.mem_wr        = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.reg_dst       = 1'b0;
    ctrl.mem_to_reg    = 1'b0;
    ctrl.load_a        = 1'b0;
    ctrl.load_b        = 1'b0;
    ctrl.alu_src_a     = 1'b0;
    ctrl.alu_src_b     = 2'b00;
    ctrl.alu_ctrl      = 3'b000;
    ctrl.alu_out_write = 1'b0;
    ctrl.pc_source     = 2'b00;
    ctrl.epc_write     = 1'b0;
    ctrl.excp_code     = 2'b00;

    case (state)
      RST: nextState = FETCH;

      FETCH: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_ctrl  = 3'b001;
        if (waitDone) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          nextState     = DECODE;
        end
      end

      DECODE: begin
        ctrl.load_a        = 1'b1;
        ctrl.load_b        = 1'b1;
        ctrl.alu_src_b     = 2'b11;
        ctrl.alu_ctrl      = 3'b001;
        ctrl.alu_out_write = 1'b1;
        nextExcpCode       = 2'b00;
        case (ctrl.opcode)
          6'h00:        nextState = rFunctOk ? EXEC_R : EXCP;
          6'h08:        nextState = EXEC_I;
          6'h23, 6'h2B: nextState = ADDR;
          6'h04, 6'h05: nextState = BR;
          6'h02:        nextState = JMP;
          default:      nextState = EXCP;
        endcase
      end

      EXEC_R: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_out_write = 1'b1;
        case (ctrl.funct)
          6'h22:   ctrl.alu_ctrl = 3'b010;
          6'h24:   ctrl.alu_ctrl = 3'b011;
          default: ctrl.alu_ctrl = 3'b001;
        endcase
        nextState = WB_R;
        if (OVF_EXCP && ctrl.overflow && (ctrl.funct != 6'h24)) begin
          nextState    = EXCP;
          nextExcpCode = 2'b01;
        end
      end

      EXEC_I: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = 2'b10;
        ctrl.alu_ctrl      = 3'b001;
        ctrl.alu_out_write = 1'b1;
        nextState          = WB_I;
        if (OVF_EXCP && ctrl.overflow) begin
          nextState    = EXCP;
          nextExcpCode = 2'b01;
        end
      end

      WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        nextState      = FETCH;
      end

      WB_I: begin
        ctrl.reg_write = 1'b1;
        nextState      = FETCH;
      end

      ADDR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = 2'b10;
        ctrl.alu_ctrl      = 3'b001;
        ctrl.alu_out_write = 1'b1;
        nextState          = (ctrl.opcode == 6'h2B) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        ctrl.iord = 2'b01;
        if (waitDone) nextState = WB_LW;
      end

      WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        nextState       = FETCH;
      end

      MEM_WR: begin
        ctrl.iord   = 2'b01;
        ctrl.mem_wr = 1'b1;
        nextState   = FETCH;
      end

      BR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_ctrl  = 3'b111;
        ctrl.pc_source = 2'b01;
        ctrl.pc_write  = (ctrl.opcode == 6'h05) ? !ctrl.eq : ctrl.eq;
        nextState      = FETCH;
      end

      JMP: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_write  = 1'b1;
        nextState      = FETCH;
      end

      EXCP: begin
        ctrl.iord      = 2'b11;
        ctrl.excp_code = excpCode;
        // EPC = PC - 4 is captured only on the first vector-read cycle
        if (waitCnt == '0) begin
          ctrl.epc_write = 1'b1;
          ctrl.alu_src_b = 2'b01;
          ctrl.alu_ctrl  = 3'b010;
        end
        if (waitDone) nextState = EXCP_LD;
      end

      EXCP_LD: begin
        ctrl.pc_source = 2'b11;
        ctrl.pc_write  = 1'b1;
        nextState      = FETCH;
      end

      default: nextState = RST;
    endcase
  end

endmodule
